// File: rtl/write_stage_buffer_if.sv
// write_stage_buffer_if: producer/consumer signals of the write staging buffer
interface write_stage_buffer_if #(
  parameter int WIDTH = 8,
  parameter int PTR_W = 2
);
  logic [WIDTH-1:0] data_in;
  logic             LoadEnable;
  logic             Flush;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  logic             overflow;
  modport master (
    output data_in, LoadEnable, Flush, out_ready,
    input  data_out, out_valid, full, empty, count, overflow
  );
  modport slave (
    input  data_in, LoadEnable, Flush, out_ready,
    output data_out, out_valid, full, empty, count, overflow
  );
endinterface

// File: rtl/write_stage_buffer.sv
// write_stage_buffer: DEPTH-entry in-order staging buffer with flush and sticky overflow
module write_stage_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic                 clk,
  input logic                 Clear,
  write_stage_buffer_if.slave bus
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             is_full, is_empty, pop, push;
  always_comb begin
    is_full    = count_q == (PTR_W+1)'(DEPTH);
    is_empty   = count_q == '0;
    pop        = !is_empty & bus.out_ready;
    push       = bus.LoadEnable & (!is_full | pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) mem_d[wr_ptr_q] = bus.data_in;
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      overflow_d = overflow_q | (bus.LoadEnable & is_full & !pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!Clear) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.data_out  = mem_q[rd_ptr_q];
  assign bus.out_valid = !is_empty;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_write_stage_buffer.sv
// tb_write_stage_buffer: queue-model scoreboard with directed and random traffic
module tb_write_stage_buffer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  logic clk = 1'b0;
  logic clear_n;
  write_stage_buffer_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();
  write_stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .Clear(clear_n), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [WIDTH-1:0] exp_q [$];
  logic ovf_m = 1'b0;
  bit started = 1'b0;
  int tests = 0, fails = 0, n_pop_exp = 0, n_xfer = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // Drive one cycle of inputs, predict its edge in the queue model, then advance past the edge.
  task automatic step(input bit cn, input bit le, input logic [WIDTH-1:0] din, input bit fl, input bit rdy);
    bit pop, push;
    clear_n = cn; bus.LoadEnable = le; bus.data_in = din; bus.Flush = fl; bus.out_ready = rdy;
    started = 1'b1;
    pop = cn && !fl && exp_q.size() > 0 && rdy;
    if (!cn) begin
      exp_q.delete();
      ovf_m = 1'b0;
    end else if (fl) exp_q.delete();
    else begin
      if (le && exp_q.size() == DEPTH && !pop) ovf_m = 1'b1;
      push = le && (exp_q.size() < DEPTH || pop);
      if (push) exp_q.push_back(din);
      if (pop) n_pop_exp++;
    end
    @(posedge clk);
    #2;
  endtask
  always begin
    @(posedge clk);
    #1;
    if (started) begin
      chk("count", 32'(bus.count), 32'(exp_q.size()));
      chk("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
      chk("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("overflow", 32'(bus.overflow), 32'(ovf_m));
      if (exp_q.size() > 0) chk("head", 32'(bus.data_out), 32'(exp_q[0]));
    end
  end
  always begin
    @(negedge clk);
    if (clear_n === 1'b1 && bus.Flush === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_xfer++;
      if (exp_q.size() == 0) chk("xfer_unexpected", 32'(bus.data_out), 32'hFFFF_FFFF);
      else chk("xfer", 32'(bus.data_out), 32'(exp_q.pop_front()));
    end
  end
  initial begin
    step(0, 1, 8'hA5, 0, 0);
    step(0, 1, 8'hA5, 0, 0);
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    foreach (exp_q[i]) chk("rst_queue_empty", 32'(i), 32'hFFFF_FFFF);
    for (int i = 1; i <= 4; i++) step(1, 1, 8'(i * 8'h11), 0, 0);
    step(1, 1, 8'h55, 0, 0);
    chk("ovf_set", 32'(bus.overflow), 32'h1);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 0, 1);
    step(1, 0, 8'h00, 1, 0);
    chk("ovf_after_flush", 32'(bus.overflow), 32'h1);
    step(0, 0, 8'h00, 0, 0);
    chk("ovf_after_clear", 32'(bus.overflow), 32'h0);
    for (int i = 1; i <= 4; i++) step(1, 1, 8'(i * 8'h11), 0, 0);
    step(1, 1, 8'h66, 0, 1);
    chk("full_push_pop_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 0, 1);
    step(1, 1, 8'h01, 0, 0);
    for (int i = 2; i <= 10; i++) step(1, 1, 8'(i), 0, 1);
    step(1, 0, 8'h00, 0, 1);
    step(1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h30 + i), 0, 0);
    step(1, 1, 8'hEE, 1, 1);
    chk("flush_valid", 32'(bus.out_valid), 32'h0);
    step(1, 1, 8'h77, 0, 0);
    chk("post_flush_head", 32'(bus.data_out), 32'h77);
    for (int i = 0; i < 500; i++)
      step(($urandom_range(99) != 0), ($urandom_range(9) < 7), 8'($urandom), ($urandom_range(39) == 0),
           ($urandom_range(1) == 1));
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 8'h00, 0, 1);
    chk("xfer_total", 32'(n_xfer), 32'(n_pop_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/write_stage_buffer.md
# write_stage_buffer

Parametrised multi-entry write-side staging buffer for the FSM-based FIFO datapath. It is the next generation of the single-register write buffer. It holds up to DEPTH words of WIDTH bits in arrival order and presents the oldest word on a valid/ready output handshake. It adds occupancy flags, a flush control and a sticky overflow indicator. It sits between the input terminal and the FIFO memory write port, absorbing input bursts while the write controller is busy.

## Interface

- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- PTR_W, 2, pointer width; must equal log2(DEPTH)

Ports:

- clk  input  1  rising-edge clock; the only clock
- Clear  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- data_in  input  WIDTH  word to store
- LoadEnable  input  1  write request for data_in this cycle
- Flush  input  1  synchronous discard of all stored entries
- data_out  output  WIDTH  oldest stored word (head entry)
- out_valid  output  1  data_out holds a stored word
- out_ready  input  1  consumer accepts data_out this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  PTR_W+1  number of stored entries, 0..DEPTH
- overflow  output  1  sticky; a write was dropped

## Operation

- Storage is a DEPTH×WIDTH register array with a write pointer wr_ptr and a read pointer rd_ptr, both PTR_W bits wide. Both pointers wrap modulo DEPTH.
- Occupancy states follow count:
  - EMPTY (count = 0).
  - PARTIAL (0 < count < DEPTH).
  - FULL (count = DEPTH).
  - State transitions are derived from count only; no separate state register is kept.
- pop = out_valid & out_ready.
- push = LoadEnable & (!full | pop). A write into a full buffer is accepted only when a pop happens in the same cycle.
- On push, mem[wr_ptr] ← data_in and wr_ptr ← wr_ptr+1.
- On pop, rd_ptr ← rd_ptr+1.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when both or neither occur.
- Dropped write: LoadEnable=1 while full and no pop. Storage, pointers and count are unchanged, and overflow ← 1. Overflow stays set until Clear. Flush does not clear it.
- Output signals:
  - data_out = mem[rd_ptr].
  - out_valid = !empty.
  - full and empty decode combinationally from count.
- Control priority per edge:
  1. Clear=0: wr_ptr, rd_ptr and count ← 0; every storage bit ← 0; overflow ← 0. LoadEnable, Flush and out_ready are ignored.
  2. Flush=1: wr_ptr, rd_ptr and count ← 0. Storage contents are left as-is. LoadEnable and pop are ignored, and the push is not counted as an overflow.
  3. Normal push/pop as above.
- Reset values of the outputs: data_out=0, out_valid=0, full=0, empty=1, count=0, overflow=0.
- Storage and pointers change only on the clk edge. There are no latches: every register holds its value when it is not updated.

## Timing

- Write-to-output latency is 1 cycle. A word pushed at edge N appears on data_out with out_valid=1 after edge N, when the buffer was empty. There is no combinational bypass from data_in to data_out.
- Handshake: a transfer occurs at the edge where out_valid=1 and out_ready=1. data_out must stay stable while out_valid=1 and out_ready=0.
- A simultaneous push and pop in PARTIAL or FULL leaves count unchanged. In FULL, the new word lands in the slot freed by the pop, because wr_ptr == rd_ptr.
- A simultaneous push and pop is impossible in EMPTY, since out_valid=0 there. The push alone takes effect.
- Wrap-around: after DEPTH pushes wr_ptr returns to 0. Ordering is preserved across the wrap.
- Clear or Flush asserted mid-stream takes effect at that edge. Any push or pop in the same cycle is lost. out_valid=0 from the next cycle.
- count, full, empty and overflow all update on the same edge as the event that causes them.

## Test plan

- Reset: hold Clear=0 for 2 cycles with LoadEnable=1 and data_in=0xA5 → after release, count=0, empty=1, out_valid=0, data_out=0x00, overflow=0.
- Fill and drain (DEPTH=4): push 0x11,0x22,0x33,0x44 with out_ready=0 → full=1 and count=4 after the 4th edge. Then set out_ready=1 → data_out reads 0x11,0x22,0x33,0x44 on consecutive cycles, then empty=1.
- Overflow: when full, push 0x55 with out_ready=0 → overflow=1, count stays 4, and the drain order remains 0x11..0x44. Then Flush=1 → count=0 and overflow still 1. Then Clear=0 → overflow=0.
- Push while full with pop: when full, assert LoadEnable=1 (data_in=0x66) and out_ready=1 → 0x11 is consumed, count stays 4, overflow=0, and the drain order is 0x22,0x33,0x44,0x66.
- Wrap-around: stream 10 words 0x01..0x0A with push and pop every cycle after the first → the output sequence is 0x01..0x0A with no gaps, count never exceeds 2, and the pointers wrap twice.
- Flush mid-operation: with 3 entries stored, assert Flush=1 together with LoadEnable=1 and out_ready=1 → next cycle count=0, out_valid=0, and no overflow is raised. A subsequent push of 0x77 appears on data_out one cycle later.
